// File: rtl/sm_accumulator.sv
// sm_accumulator: sums a frame of COUNT sign-magnitude samples into a saturating
// sign-magnitude accumulator and presents the total over a valid/ready handshake.
module sm_accumulator #(
    parameter int IN_W  = 9,
    parameter int ACC_W = 16,
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);
    localparam int MW = ACC_W - 1;
    localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [MW-1:0] in_mag, acc_mag, res_mag;
    logic [MW:0]   mag_sum;
    logic          in_sgn, res_sgn, same, sat, accept, acc_ge;

    // -0 on the input is folded to +0 so it can never flip the accumulator sign
    assign in_mag  = MW'(in_sum[IN_W-2:0]);
    assign in_sgn  = in_sum[IN_W-1] & (|in_sum[IN_W-2:0]);
    assign acc_mag = acc_q[MW-1:0];
    assign mag_sum = {1'b0, acc_mag} + {1'b0, in_mag};
    assign same    = in_sgn == acc_q[MW];
    assign acc_ge  = acc_mag >= in_mag;
    assign sat     = same & mag_sum[MW];
    assign res_mag = same ? (sat ? '1 : mag_sum[MW-1:0])
                          : (acc_ge ? acc_mag - in_mag : in_mag - acc_mag);
    assign res_sgn = (acc_ge ? acc_q[MW] : in_sgn) & (|res_mag);

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
        if (accept) begin
            acc_d = {res_sgn, res_mag};
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | sat;
            if (cnt_q == CW'(COUNT - 1)) state_d = DONE;
        end
        if (out_valid && out_ready) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_sm_accumulator.sv
// tb_sm_accumulator: drives a 16-bit and a 10-bit accumulator (COUNT=4) with identical
// frames; expected totals come from a signed-integer model and are checked by a monitor.
module tb_sm_accumulator;
    logic        clk = 0, reset, start, in_valid, out_ready;
    logic [8:0]  in_sum;
    logic        in_ready, out_valid, overflow, busy;
    logic [15:0] acc_out;
    logic        in_ready_b, out_valid_b, overflow_b, busy_b;
    logic [9:0]  acc_out_b;

    always #5 clk = ~clk;

    sm_accumulator #(.IN_W(9), .ACC_W(16), .COUNT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .overflow(overflow), .busy(busy));

    sm_accumulator #(.IN_W(9), .ACC_W(10), .COUNT(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_sum(in_sum), .out_valid(out_valid_b), .out_ready(out_ready), .acc_out(acc_out_b),
        .overflow(overflow_b), .busy(busy_b));

    typedef struct packed {
        logic [15:0] a;
        logic        o;
        logic [9:0]  b;
        logic        p;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] smp[$];
    int         n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame total as a plain signed integer, clamped to +/-(2^(w-1)-1) after every sample.
    function automatic void ref_sum(input int w, output logic [15:0] r, output logic o);
        int acc, mx, v;
        acc = 0;
        mx  = (1 << (w - 1)) - 1;
        o   = 1'b0;
        foreach (smp[i]) begin
            v = int'(smp[i][7:0]);
            if (smp[i][8]) v = -v;
            acc += v;
            if (acc > mx) begin acc = mx; o = 1'b1; end
            if (acc < -mx) begin acc = -mx; o = 1'b1; end
        end
        r = acc < 0 ? ((16'd1 << (w - 1)) | 16'(-acc)) : 16'(acc);
    endfunction

    always @(negedge clk) begin
        if (!reset && (out_valid || out_valid_b)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                chk("acc16", acc_out, sb[0].a);
                chk("ovf16", overflow, sb[0].o);
                chk("acc10", acc_out_b, sb[0].b);
                chk("ovf10", overflow_b, sb[0].p);
                chk("valid10", out_valid_b, 1);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int hold, input bit gaps);
        exp_t        e;
        logic [15:0] t;
        ref_sum(16, e.a, e.o);
        ref_sum(10, t, e.p);
        e.b = t[9:0];
        sb.push_back(e);
        start    = 1;
        in_valid = 1;
        in_sum   = 9'($urandom);
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);
        foreach (smp[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 0;
                in_sum   = 9'($urandom);
                tick();
            end
            in_valid = 1;
            in_sum   = smp[i];
            chk("in_ready_accum", in_ready, 1);
            tick();
        end
        in_valid = 0;
        chk("out_valid_rise", out_valid, 1);
        repeat (hold) begin
            in_valid = 1'($urandom);
            in_sum   = 9'($urandom);
            tick();
            chk("in_ready_done", in_ready, 0);
            chk("out_valid_hold", out_valid, 1);
        end
        in_valid  = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("out_valid_fall", out_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; start = 0; in_valid = 0; out_ready = 0; in_sum = '0;
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_ovf", overflow, 0);
        reset = 0;
        tick();
        smp = '{9'h005, 9'h103, 9'h00A, 9'h10C};
        frame(0, 0);
        chk("t1_acc_plus0", acc_out, 16'h0000);
        smp = '{9'h164, 9'h164, 9'h032, 9'h107};
        frame(1, 0);
        chk("t2_acc", acc_out, 16'h809D);
        smp = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
        frame(0, 0);
        chk("t3_acc10", acc_out_b, 10'h1FF);
        chk("t3_ovf10", overflow_b, 1);
        smp = '{9'h001, 9'h002, 9'h003, 9'h004};
        frame(5, 0);
        chk("t3_ovf_cleared", overflow_b, 0);
        smp = '{9'h100, 9'h007, 9'h008, 9'h102};
        frame(2, 1);
        chk("t5_acc", acc_out, 16'h000D);
        start = 1;
        tick();
        start    = 0;
        in_valid = 1;
        in_sum   = 9'h0FF;
        repeat (2) tick();
        in_valid = 0;
        reset    = 1;
        tick();
        reset = 0;
        chk("t6_busy", busy, 0);
        chk("t6_acc", acc_out, 0);
        chk("t6_in_ready", in_ready, 0);
        repeat (8) tick();
        chk("t6_no_valid", out_valid, 0);
        smp = '{9'h005, 9'h103, 9'h00A, 9'h10C};
        frame(0, 1);
        chk("t6_acc", acc_out, 16'h0000);
        for (int f = 0; f < 40; f++) begin
            smp.delete();
            repeat (4) smp.push_back(9'($urandom));
            frame($urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
